// File: rtl/instr_issue_queue.sv
// In-order instruction/operand issue queue: valid/ready FIFO that drops and counts NOP opcodes.
// Optional even-parity check on accepted entries when ISSUE_PARITY_EN is defined.
module instr_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_opcode,
  input  logic [23:0]              in_addr,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_opcode,
  output logic [23:0]              out_addr,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         nop_cnt
`ifdef ISSUE_PARITY_EN
  ,
  input  logic                     in_parity,
  output logic                     parity_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]    PTR_ONE = 1;
  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [CNT_W-1:0] NOP_ONE = 1;

  logic [7:0]       mem_op   [DEPTH];
  logic [23:0]      mem_addr [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  logic accept, par_ok, do_push, do_pop, is_nop;

`ifdef ISSUE_PARITY_EN
  assign par_ok = ~^{in_opcode, in_addr, in_parity};
`else
  assign par_ok = 1'b1;
`endif

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready && !flush;
  assign is_nop    = (in_opcode == 8'h00);
  assign do_push   = accept && par_ok && !is_nop;
  assign do_pop    = out_valid && out_ready && !flush;

  // Head is read straight from registered storage, so a push is visible one edge later.
  assign out_opcode = mem_op[rd_ptr];
  assign out_addr   = mem_addr[rd_ptr];
  assign out_data   = mem_data[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i]   <= '0;
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_op[wr_ptr]   <= in_opcode;
        mem_addr[wr_ptr] <= in_addr;
        mem_data[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      nop_cnt <= '0;
    else if (flush)
      nop_cnt <= '0;
    else if (accept && par_ok && is_nop && (nop_cnt != '1))
      nop_cnt <= nop_cnt + NOP_ONE;
  end

`ifdef ISSUE_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else if (flush)
      parity_err <= 1'b0;
    else if (accept && !par_ok)
      parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue (plus a CNT_W=2 instance for saturation).
module tb_instr_issue_queue;

  logic        clk, rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_opcode, out_opcode;
  logic [23:0] in_addr, out_addr;
  logic [31:0] in_data, out_data;
  logic [3:0]  count;
  logic [15:0] nop_cnt;
  logic        bad_par;

  logic        s_valid, s_in_ready, s_out_valid;
  logic [7:0]  s_out_opcode;
  logic [23:0] s_out_addr;
  logic [31:0] s_out_data;
  logic [3:0]  s_count;
  logic [1:0]  s_nop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ISSUE_PARITY_EN
  logic in_parity, parity_err, s_parity_err;
  assign in_parity = (^{in_opcode, in_addr}) ^ bad_par;
`endif

  instr_issue_queue #(.WIDTH(32), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_addr(out_addr), .out_data(out_data),
    .count(count), .nop_cnt(nop_cnt)
`ifdef ISSUE_PARITY_EN
    , .in_parity(in_parity), .parity_err(parity_err)
`endif
  );

  instr_issue_queue #(.WIDTH(32), .DEPTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_valid), .in_ready(s_in_ready),
    .in_opcode(8'h00), .in_addr(24'h000000), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_opcode(s_out_opcode), .out_addr(s_out_addr), .out_data(s_out_data),
    .count(s_count), .nop_cnt(s_nop_cnt)
`ifdef ISSUE_PARITY_EN
    , .in_parity(1'b0), .parity_err(s_parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_flags got v=%b r=%b c=%0d exp v=0 r=1 c=0", out_valid, in_ready, count);
    end
    checks++;
    if ({nop_cnt, out_opcode, out_addr, out_data} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data got nop=%0d op=%h addr=%h data=%h exp all 0", nop_cnt, out_opcode, out_addr, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_opcode = 8'h11; in_addr = 24'h000100; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_opcode, out_addr, out_data} !== {1'b1, 8'h11, 24'h000100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_issue got v=%b op=%h addr=%h data=%h exp v=1 op=11 addr=000100 data=deadbeef",
               out_valid, out_opcode, out_addr, out_data);
    end
    tick();
    checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_drain got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_full_wrap();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_opcode = 8'h80 + 8'(i); in_addr = 24'(i); in_data = 32'hA0000000 + 32'(i);
      tick();
    end
    checks++;
    if ({count, in_ready} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL full got c=%0d r=%b exp c=8 r=0", count, in_ready);
    end
    in_opcode = 8'h99;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL full_reject got c=%0d exp 8", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_opcode, out_addr, out_data} !== {1'b1, 8'h80 + 8'(i), 24'(i), 32'hA0000000 + 32'(i)}) begin
        errors++;
        $display("FAIL wrap_order[%0d] got v=%b op=%h addr=%h data=%h exp op=%h", i, out_valid, out_opcode,
                 out_addr, out_data, 8'h80 + 8'(i));
      end
      tick();
    end
    checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_empty got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_nop();
    logic [7:0] ops [5];
    ops[0] = 8'h00; ops[1] = 8'h22; ops[2] = 8'h00; ops[3] = 8'h22; ops[4] = 8'h00;
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_opcode = ops[i]; in_addr = 24'h000220; in_data = 32'h2222;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({count, nop_cnt} !== {4'd2, 16'd3}) begin
      errors++;
      $display("FAIL nop_drop got c=%0d nop=%0d exp c=2 nop=3", count, nop_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, out_opcode} !== {1'b1, 8'h22}) begin
        errors++;
        $display("FAIL nop_issue[%0d] got v=%b op=%h exp v=1 op=22", i, out_valid, out_opcode);
      end
      tick();
    end
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    checks++;
    if (s_nop_cnt !== 2'd3) begin
      errors++;
      $display("FAIL nop_saturate got %0d exp 3", s_nop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_opcode = 8'h40 + 8'(i); in_addr = 24'h400 + 24'(i); in_data = 32'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_opcode = 8'h44 + 8'(i); in_addr = 24'h404 + 24'(i); in_data = 32'(i + 4);
      checks++;
      if ({out_valid, out_opcode, out_addr} !== {1'b1, 8'h40 + 8'(i), 24'h400 + 24'(i)}) begin
        errors++;
        $display("FAIL b2b_order[%0d] got v=%b op=%h addr=%h exp op=%h", i, out_valid, out_opcode, out_addr,
                 8'h40 + 8'(i));
      end
      tick();
      checks++;
      if (count !== 4'd4) begin
        errors++;
        $display("FAIL b2b_count[%0d] got %0d exp 4", i, count);
      end
    end
    flush = 1'b1; in_opcode = 8'h77;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %b exp 1", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
    tick();
    checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush_lost got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_opcode = 8'h50 + 8'(i); in_addr = 24'(i); in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_count got %0d exp 5", count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({count, out_valid, in_ready} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got c=%0d v=%b r=%b exp c=0 v=0 r=1", count, out_valid, in_ready);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h55; in_addr = 24'h000555; in_data = 32'h55555555; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_opcode, out_addr, out_data} !== {1'b1, 8'h55, 24'h000555, 32'h55555555}) begin
      errors++;
      $display("FAIL post_reset_issue got v=%b op=%h addr=%h data=%h exp v=1 op=55", out_valid, out_opcode,
               out_addr, out_data);
    end
    tick();
  endtask

`ifdef ISSUE_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h33; in_addr = 24'h000000; in_data = 32'h3333; bad_par = 1'b1;
    tick();
    in_valid = 1'b0; bad_par = 1'b0;
    checks++;
    if ({count, out_valid, parity_err, nop_cnt} !== {4'd0, 1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL parity_drop got c=%0d v=%b perr=%b nop=%0d exp c=0 v=0 perr=1 nop=0", count, out_valid,
               parity_err, nop_cnt);
    end
    in_valid = 1'b1; in_opcode = 8'h34; in_addr = 24'h000034; in_data = 32'h3434;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_opcode, parity_err} !== {1'b1, 8'h34, 1'b1}) begin
      errors++;
      $display("FAIL parity_good got v=%b op=%h perr=%b exp v=1 op=34 perr=1", out_valid, out_opcode, parity_err);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({parity_err, count} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL parity_flush got perr=%b c=%0d exp perr=0 c=0", parity_err, count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s_valid = 1'b0; bad_par = 1'b0;
    in_opcode = 8'h00; in_addr = 24'h0; in_data = 32'h0;
    test_reset();
    tick();
    test_single();
    test_full_wrap();
    test_nop();
    test_back_to_back();
    test_async_reset();
`ifdef ISSUE_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
